muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_if.sv | 36 +++
 rtl/muldiv_ctrl.sv | 102 ++++++++++
 tb/tb_muldiv_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between the CPU pipeline and the mult/div controller.
// MULDIV_HILO_WRITE_EN adds the mthi/mtlo write port (hi_we, lo_we, wdata).
interface muldiv_ctrl_if;
  logic        op_start;
  logic        op_sel;
  logic [31:0] value_A, value_B;
  logic [31:0] mult_hi, mult_low, div_hi, div_low;
  logic [31:0] opA, opB;
  logic        multInit, divInit;
  logic        busy, done, div_zero;
  logic [31:0] hi, low;
`ifdef MULDIV_HILO_WRITE_EN
  logic        hi_we, lo_we;
  logic [31:0] wdata;

  modport slave (
    input  op_start, op_sel, value_A, value_B, mult_hi, mult_low, div_hi, div_low,
           hi_we, lo_we, wdata,
    output opA, opB, multInit, divInit, busy, done, div_zero, hi, low
  );
  modport master (
    output op_start, op_sel, value_A, value_B, mult_hi, mult_low, div_hi, div_low,
           hi_we, lo_we, wdata,
    input  opA, opB, multInit, divInit, busy, done, div_zero, hi, low
  );
`else
  modport slave (
    input  op_start, op_sel, value_A, value_B, mult_hi, mult_low, div_hi, div_low,
    output opA, opB, multInit, divInit, busy, done, div_zero, hi, low
  );
  modport master (
    output op_start, op_sel, value_A, value_B, mult_hi, mult_low, div_hi, div_low,
    input  opA, opB, multInit, divInit, busy, done, div_zero, hi, low
  );
`endif
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for an external multi-cycle mult/div unit, owning the HI/LO registers.
// Optional MULDIV_HILO_WRITE_EN enables direct HI/LO writes (mthi/mtlo) when not busy.
module muldiv_ctrl #(
  parameter int CYCLES = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE, DZERO} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_sel;
  logic [31:0]   r_opA, r_opB, r_hi, r_low;
  logic          w_open, w_accept, w_cnt_zero;

  assign w_open     = (r_state == IDLE) || (r_state == DONE);
  assign w_accept   = bus.op_start && w_open;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        w_next = IDLE;
        if (w_accept)
          w_next = (bus.op_sel && (bus.value_B == 32'd0)) ? DZERO : LAUNCH;
      end
      LAUNCH:  w_next = WAIT;
      WAIT:    if (w_cnt_zero) w_next = DONE;
      DZERO:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status and init pulses decode straight from the registered state.
  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.div_zero = 1'b0;
    bus.multInit = 1'b0;
    bus.divInit  = 1'b0;
    case (r_state)
      LAUNCH: begin
        bus.busy     = 1'b1;
        bus.multInit = ~r_sel;
        bus.divInit  = r_sel;
      end
      WAIT:  bus.busy = 1'b1;
      DONE:  bus.done = 1'b1;
      DZERO: begin
        bus.done     = 1'b1;
        bus.div_zero = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_hi    <= '0;
      r_low   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_opA <= bus.value_A;
        r_opB <= bus.value_B;
        r_sel <= bus.op_sel;
      end
`ifdef MULDIV_HILO_WRITE_EN
      // Result writes only happen in WAIT, so these never collide with them.
      if (w_open && bus.hi_we) r_hi  <= bus.wdata;
      if (w_open && bus.lo_we) r_low <= bus.wdata;
`endif
      case (r_state)
        LAUNCH: r_cnt <= CW'(CYCLES - 1);
        WAIT: begin
          if (w_cnt_zero) begin
            r_hi  <= r_sel ? bus.div_hi  : bus.mult_hi;
            r_low <= r_sel ? bus.div_low : bus.mult_low;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.opA = r_opA;
  assign bus.opB = r_opB;
  assign bus.hi  = r_hi;
  assign bus.low = r_low;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table for single ops plus sequences
// for ignored start, back-to-back start, mid-op reset and optional HI/LO writes.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if m ();
  muldiv_ctrl #(.CYCLES(32)) dut (.clk(clk), .reset(reset), .bus(m.slave));

  // Behavioural unit model fed by the controller's latched operands.
  logic [63:0] w_prod;
  assign w_prod     = {32'd0, m.opA} * {32'd0, m.opB};
  assign m.mult_hi  = w_prod[63:32];
  assign m.mult_low = w_prod[31:0];
  assign m.div_hi   = (m.opB == 32'd0) ? 32'd0 : m.opA % m.opB;
  assign m.div_low  = (m.opB == 32'd0) ? 32'd0 : m.opA / m.opB;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Per-run observations.
  int n_done, d_first, d_last, n_mi, mi_c, n_di, di_c, n_both, n_busy, b_first;
  logic [31:0] s_hi, s_lo, s_opa;
  logic        s_dz;
  logic [136:0] snap;

  task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                        input int inj_c, input logic inj_sel, input logic [31:0] inj_a,
                        input logic [31:0] inj_b, input int rst_c);
    n_done = 0; d_first = 0; d_last = 0; n_mi = 0; mi_c = 0; n_di = 0; di_c = 0;
    n_both = 0; n_busy = 0; b_first = 0; s_hi = '0; s_lo = '0; s_opa = '0; s_dz = 1'b0;
    snap = '1;
    @(negedge clk);
    m.op_start = 1'b1; m.op_sel = sel; m.value_A = a; m.value_B = b;
    @(posedge clk);
    #1 m.op_start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (m.done) begin
        n_done++; if (d_first == 0) d_first = c; d_last = c;
        s_hi = m.hi; s_lo = m.low; s_dz = m.div_zero; s_opa = m.opA;
      end
      if (m.multInit) begin n_mi++; if (mi_c == 0) mi_c = c; end
      if (m.divInit)  begin n_di++; if (di_c == 0) di_c = c; end
      if (m.multInit && m.divInit) n_both++;
      if (m.busy) begin n_busy++; if (b_first == 0) b_first = c; end
      if (rst_c > 0 && c == rst_c + 1)
        snap = {m.opA, m.opB, m.hi, m.low, m.busy, m.done, m.div_zero, m.multInit, m.divInit, 4'd0};
      if (inj_c > 0 && c == inj_c) begin
        m.op_start = 1'b1; m.op_sel = inj_sel; m.value_A = inj_a; m.value_B = inj_b;
      end else if (inj_c > 0 && c == inj_c + 1) m.op_start = 1'b0;
      if (rst_c > 0 && c == rst_c) reset = 1'b1;
      else if (rst_c > 0 && c == rst_c + 1) reset = 1'b0;
    end
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] a, b, ehi, elo;
    logic        edz;
  } vec_t;
  vec_t vt[8];

  initial begin
    m.op_start = 1'b0; m.op_sel = 1'b0; m.value_A = '0; m.value_B = '0;
`ifdef MULDIV_HILO_WRITE_EN
    m.hi_we = 1'b0; m.lo_we = 1'b0; m.wdata = '0;
`endif
    // DZERO rows expect the previous row's HI/LO unchanged.
    vt[0] = '{1'b1, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vt[1] = '{1'b0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0001,  32'h0000_0000,  1'b0};
    vt[2] = '{1'b1, 32'd5,          32'd0,          32'h0000_0001,  32'h0000_0000,  1'b1};
    vt[3] = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd15,         1'b0};
    vt[4] = '{1'b1, 32'hFFFF_FFFF,  32'h10,         32'hF,          32'h0FFF_FFFF,  1'b0};
    vt[5] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  1'b0};
    vt[6] = '{1'b1, 32'd7,          32'd0,          32'hFFFF_FFFE,  32'h0000_0001,  1'b1};
    vt[7] = '{1'b1, 32'd3,          32'd9,          32'd3,          32'd0,          1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    chk("reset_flags", {m.busy, m.done, m.div_zero, m.multInit, m.divInit}, 0);
    chk("reset_opA", m.opA, 0);
    chk("reset_opB", m.opB, 0);
    chk("reset_hilo", {m.hi, m.low}, 0);

    foreach (vt[i]) begin
      run_op(vt[i].sel, vt[i].a, vt[i].b, 0, 1'b0, 32'd0, 32'd0, 0);
      chk($sformatf("v%0d_done_cyc", i), d_first, vt[i].edz ? 1 : 34);
      chk($sformatf("v%0d_n_done", i), n_done, 1);
      chk($sformatf("v%0d_n_multInit", i), n_mi, (!vt[i].edz && !vt[i].sel) ? 1 : 0);
      chk($sformatf("v%0d_n_divInit", i), n_di, (!vt[i].edz && vt[i].sel) ? 1 : 0);
      chk($sformatf("v%0d_init_cyc", i), mi_c + di_c, vt[i].edz ? 0 : 1);
      chk($sformatf("v%0d_init_both", i), n_both, 0);
      chk($sformatf("v%0d_busy_cnt", i), n_busy, vt[i].edz ? 0 : 33);
      chk($sformatf("v%0d_busy_first", i), b_first, vt[i].edz ? 0 : 1);
      chk($sformatf("v%0d_div_zero", i), s_dz, vt[i].edz);
      chk($sformatf("v%0d_hi", i), s_hi, vt[i].ehi);
      chk($sformatf("v%0d_low", i), s_lo, vt[i].elo);
      chk($sformatf("v%0d_opA", i), s_opa, vt[i].a);
    end

    // Start request during WAIT must be ignored.
    run_op(1'b1, 32'd100, 32'd7, 10, 1'b0, 32'd999, 32'd3, 0);
    chk("ign_n_done", n_done, 1);
    chk("ign_done_cyc", d_first, 34);
    chk("ign_n_multInit", n_mi, 0);
    chk("ign_opA", s_opa, 100);
    chk("ign_hilo", {s_hi, s_lo}, {32'd2, 32'd14});

    // Start accepted in DONE chains straight into LAUNCH.
    run_op(1'b0, 32'd3, 32'd5, 34, 1'b1, 32'd100, 32'd7, 0);
    chk("chain_n_done", n_done, 2);
    chk("chain_done_first", d_first, 34);
    chk("chain_done_last", d_last, 68);
    chk("chain_multInit_cyc", mi_c, 1);
    chk("chain_divInit_cyc", di_c, 35);
    chk("chain_busy_cnt", n_busy, 66);
    chk("chain_hilo", {s_hi, s_lo}, {32'd2, 32'd14});

    // Reset in cycle 20 of a mult wipes everything and suppresses done.
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, 32'd0, 32'd0, 20);
    chk("rst_mid_snapshot", snap[136:64], 0);
    chk("rst_mid_snapshot_lo", snap[63:0], 0);
    chk("rst_mid_n_done", n_done, 0);
    chk("rst_mid_hilo", {m.hi, m.low}, 0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; m.op_start = 1'b1; m.op_sel = 1'b0; m.value_A = 32'd9; m.value_B = 32'd9;
    @(posedge clk);
    #1 reset = 1'b0; m.op_start = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", m.busy, 0);
    chk("rst_prio_opA", m.opA, 0);

`ifdef MULDIV_HILO_WRITE_EN
    @(negedge clk);
    m.hi_we = 1'b1; m.wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 m.hi_we = 1'b0;
    @(negedge clk);
    chk("mthi_idle", m.hi, 32'hDEAD_BEEF);

    m.op_start = 1'b1; m.op_sel = 1'b0; m.value_A = 32'd3; m.value_B = 32'd5;
    @(posedge clk);
    #1 m.op_start = 1'b0;
    repeat (5) @(negedge clk);
    m.hi_we = 1'b1; m.lo_we = 1'b1; m.wdata = 32'h1234_5678;
    @(negedge clk);
    m.hi_we = 1'b0; m.lo_we = 1'b0;
    chk("mthi_wait_dropped", {m.hi, m.low}, {32'hDEAD_BEEF, 32'd0});
    repeat (40) @(negedge clk);
    chk("mthi_then_result", {m.hi, m.low}, {32'd0, 32'd15});

    m.hi_we = 1'b1; m.wdata = 32'hCAFE_F00D;
    m.op_start = 1'b1; m.op_sel = 1'b0; m.value_A = 32'h0001_0000; m.value_B = 32'h0001_0000;
    @(posedge clk);
    #1 m.op_start = 1'b0; m.hi_we = 1'b0;
    @(negedge clk);
    chk("mthi_with_start_hi", m.hi, 32'hCAFE_F00D);
    chk("mthi_with_start_busy", m.busy, 1);
    repeat (40) @(negedge clk);
    chk("mthi_with_start_result", {m.hi, m.low}, {32'd1, 32'd0});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
